bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 121 ++++++++++++
 tb/tb_bit_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one word per handshake, shifted out one bit per
// cycle, followed by an optional run of idle (zero) cycles before the next word.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(WIDTH - 2);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;

  logic             last_bit;
  logic             xfer;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] din_rest;
  logic [WIDTH-1:0] sreg_rest;

  // Handshake: a word moves on a rising edge where din_valid and din_ready are
  // both high; din_ready never depends on din_valid, and din is don't-care
  // while din_ready is low.
  always_comb begin
    last_bit  = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
    din_ready = (state == ST_IDLE) || (last_bit && (GAP == 0));
    xfer      = din_valid && din_ready;
    first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    next_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    din_rest  = MSB_FIRST ? (din << 1) : (din >> 1);
    sreg_rest = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // The first bit goes straight to sout on the load edge, so sreg only holds
  // the bits still to come.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else if (xfer) begin
      state      <= ST_SHIFT;
      sreg       <= din_rest;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= first_bit;
      sout_valid <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state      <= (GAP > 0) ? ST_GAP : ST_IDLE;
            gap_cnt    <= GAP_LOAD;
            sreg       <= '0;
            bit_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
          end else begin
            sreg    <= sreg_rest;
            bit_cnt <= bit_cnt + 1'b1;
            sout    <= next_bit;
            done    <= (bit_cnt == PEN_CNT);
          end
        end
        ST_GAP: begin
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Three serializer lanes (MSB/GAP=1, LSB/GAP=0, MSB/GAP=3) driven in parallel
// and checked cycle by cycle against a timeline model of each word.
module tb_bit_serializer;

  logic       clk;
  logic       rstn;
  logic [7:0] din        [3];
  logic       din_valid  [3];
  logic       din_ready  [3];
  logic       sout       [3];
  logic       sout_valid [3];
  logic       busy       [3];
  logic       done       [3];
  logic [1:0] dbg_state  [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit end_check = 1'b0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check_bit(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d cycle %0d actual %0b expected %0b", name, k, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane %0d cycle %0d actual %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- DUTs + scoreboard per lane ----------------
  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int G = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    localparam bit M = (k != 1);

    bit_serializer #(.WIDTH(8), .GAP(G), .MSB_FIRST(M)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .din        (din[k]),
      .din_valid  (din_valid[k]),
      .din_ready  (din_ready[k]),
      .sout       (sout[k]),
      .sout_valid (sout_valid[k]),
      .busy       (busy[k]),
      .done       (done[k]),
      .dbg_state  (dbg_state[k])
    );

    // Entries are {done, bit}, one per expected serial cycle.
    logic [1:0] exp_q[$];
    int  ready_cyc = 0;
    int  busy_end  = -1;
    int  bits_end  = -1;
    bit  end_done  = 1'b0;

    always @(negedge clk) begin : mon
      logic [1:0] e;
      logic       exp_ready;
      if (!rstn) begin
        exp_q.delete();
        ready_cyc = 0;
        busy_end  = -1;
        bits_end  = -1;
        check_bit("rst_sout", k, sout[k], 1'b0);
        check_bit("rst_sout_valid", k, sout_valid[k], 1'b0);
        check_bit("rst_busy", k, busy[k], 1'b0);
        check_bit("rst_done", k, done[k], 1'b0);
        check_bit("rst_state_idle", k, dbg_state[k] == 2'd0, 1'b1);
      end else begin
        exp_ready = (cyc >= ready_cyc);
        check_bit("din_ready", k, din_ready[k], exp_ready);
        check_bit("busy", k, busy[k], cyc <= busy_end);
        check_bit("sout_valid", k, sout_valid[k], cyc <= bits_end);
        if (sout_valid[k]) begin
          if (exp_q.size() == 0) begin
            check_int("unexpected_bit", k, 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_bit("sout", k, sout[k], e[0]);
            check_bit("done", k, done[k], e[1]);
          end
        end else begin
          check_bit("idle_sout_zero", k, sout[k], 1'b0);
          check_bit("idle_done_zero", k, done[k], 1'b0);
        end
        // A word offered while the model says ready is taken at the next edge;
        // its bits fill the following 8 cycles in transmission order.
        if (exp_ready && din_valid[k]) begin
          for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 7), din[k][M ? 7 - i : i]});
          bits_end  = cyc + 8;
          busy_end  = cyc + 8 + G;
          ready_cyc = cyc + 8 + ((G == 0) ? 0 : G + 1);
        end
        if (end_check && !end_done) begin
          check_int("drain", k, exp_q.size(), 0);
          end_done = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int k, input logic [7:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    din[k]       = w;
    din_valid[k] = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = din_ready[k];
      @(posedge clk);
      n++;
    end
    if (!acc) check_bit("send_timeout", k, acc, 1'b1);
    #1;
    din_valid[k] = 1'b0;
    din[k]       = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic traffic(input int k);
    case (k)
      0: begin
        send(0, 8'hA5);
        send(0, 8'h3C);     // offered during SHIFT, must wait for IDLE
      end
      1: begin
        send(1, 8'h01);
        idle_cycles(3);
        send(1, 8'hFF);
        send(1, 8'h00);     // back-to-back on the last-bit cycle
      end
      default: send(2, 8'h50);
    endcase
    for (int i = 0; i < 20; i++) begin
      idle_cycles($urandom_range(0, 3));
      send(k, 8'($urandom));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k]       = 8'h00;
      din_valid[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    fork
      traffic(0);
      traffic(1);
      traffic(2);
    join
    idle_cycles(15);

    // Reset during the 4th bit of a word: outputs must drop without a clock.
    send(0, 8'hC3);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_bit("async_sout", 0, sout[0], 1'b0);
    check_bit("async_sout_valid", 0, sout_valid[0], 1'b0);
    check_bit("async_busy", 0, busy[0], 1'b0);
    check_bit("async_done", 0, done[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    // Lane 2 offers on the very first edge after release; lane 0 stays idle.
    send(2, 8'h96);
    idle_cycles(4);
    send(0, 8'hC3);
    idle_cycles(15);

    end_check = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
